// File: rtl/simple_risc_pkg.sv
// Shared SimpleRISC encoding definitions: opcodes, NOP word, format classifier
// and the loader state type.
package simple_risc_pkg;

   localparam logic [4:0] OP_ADD  = 5'd0;
   localparam logic [4:0] OP_SUB  = 5'd1;
   localparam logic [4:0] OP_MUL  = 5'd2;
   localparam logic [4:0] OP_DIV  = 5'd3;
   localparam logic [4:0] OP_MOD  = 5'd4;
   localparam logic [4:0] OP_CMP  = 5'd5;
   localparam logic [4:0] OP_AND  = 5'd6;
   localparam logic [4:0] OP_OR   = 5'd7;
   localparam logic [4:0] OP_NOT  = 5'd8;
   localparam logic [4:0] OP_MOV  = 5'd9;
   localparam logic [4:0] OP_LSL  = 5'd10;
   localparam logic [4:0] OP_LSR  = 5'd11;
   localparam logic [4:0] OP_ASR  = 5'd12;
   localparam logic [4:0] OP_NOP  = 5'd13;
   localparam logic [4:0] OP_LD   = 5'd14;
   localparam logic [4:0] OP_ST   = 5'd15;
   localparam logic [4:0] OP_BEQ  = 5'd16;
   localparam logic [4:0] OP_BGT  = 5'd17;
   localparam logic [4:0] OP_B    = 5'd18;
   localparam logic [4:0] OP_CALL = 5'd19;
   localparam logic [4:0] OP_RET  = 5'd20;

   localparam logic [31:0] NOP_WORD = 32'h6800_0000;

   typedef enum logic [2:0] {
      FMT_3ADDR,    // op, I, rd, rs1, src2
      FMT_CMP,      // rd field forced to zero
      FMT_2ADDR,    // rs1 field forced to zero
      FMT_NOARG,    // opcode only
      FMT_BRANCH,   // opcode + 27-bit word offset
      FMT_ILLEGAL
   } fmt_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_DONE
   } load_state_e;

   function automatic fmt_e classify_op(input logic [4:0] op);
      fmt_e fmt;
      case (op)
         OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MOD,
         OP_AND, OP_OR, OP_LSL, OP_LSR, OP_ASR,
         OP_LD, OP_ST:                      fmt = FMT_3ADDR;
         OP_CMP:                            fmt = FMT_CMP;
         OP_NOT, OP_MOV:                    fmt = FMT_2ADDR;
         OP_NOP, OP_RET:                    fmt = FMT_NOARG;
         OP_BEQ, OP_BGT, OP_B, OP_CALL:     fmt = FMT_BRANCH;
         default:                           fmt = FMT_ILLEGAL;
      endcase
      return fmt;
   endfunction

endpackage

// File: rtl/inst_field_packer.sv
// Combinational packer: decoded SimpleRISC fields -> 32-bit instruction word.
// Illegal opcodes produce the NOP word and raise the illegal flag.
module inst_field_packer
   import simple_risc_pkg::*;
(
   input  logic [4:0]  op,
   input  logic        imm_en,
   input  logic [3:0]  rd,
   input  logic [3:0]  rs1,
   input  logic [3:0]  rs2,
   input  logic [17:0] imm,
   input  logic [26:0] offset,
   output logic [31:0] word,
   output logic        illegal
);

   logic [17:0] src2;

   assign src2 = imm_en ? imm : {rs2, 14'b0};

   always_comb begin
      // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
      word    = '0;
      illegal = 1'b0;
      case (classify_op(op))
         FMT_3ADDR:  word = {op, imm_en, rd, rs1, src2};
         FMT_CMP:    word = {op, imm_en, 4'b0, rs1, src2};
         FMT_2ADDR:  word = {op, imm_en, rd, 4'b0, src2};
         FMT_NOARG:  word = {op, 27'b0};
         FMT_BRANCH: word = {op, offset};
         default: begin
            word    = NOP_WORD;
            illegal = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/inst_encoder_loader.sv
// Boot/program loader: accepts decoded field tuples, encodes them and writes
// them to consecutive IMEM words starting at BASE_ADDR.
module inst_encoder_loader
   import simple_risc_pkg::*;
#(
   parameter int ADDR_W    = 8,
   parameter int BASE_ADDR = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_last,
   input  logic [4:0]        in_op,
   input  logic              in_imm_en,
   input  logic [3:0]        in_rd,
   input  logic [3:0]        in_rs1,
   input  logic [3:0]        in_rs2,
   input  logic [17:0]       in_imm,
   input  logic [26:0]       in_offset,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              busy,
   output logic              done,
   output logic              err_illegal,
   output logic [ADDR_W:0]   inst_count
);

   localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

   load_state_e       state_q, state_d;
   logic [ADDR_W-1:0] next_addr_q, next_addr_d;
   logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
   logic [31:0]       imem_wdata_q, imem_wdata_d;
   logic              imem_we_q, imem_we_d;
   logic              err_q, err_d;
   logic [ADDR_W:0]   count_q, count_d;

   logic [31:0]       packed_word;
   logic              packed_illegal;

   inst_field_packer u_packer (
      .op      (in_op),
      .imm_en  (in_imm_en),
      .rd      (in_rd),
      .rs1     (in_rs1),
      .rs2     (in_rs2),
      .imm     (in_imm),
      .offset  (in_offset),
      .word    (packed_word),
      .illegal (packed_illegal)
   );

   always_comb begin
      state_d      = state_q;
      next_addr_d  = next_addr_q;
      imem_addr_d  = imem_addr_q;
      imem_wdata_d = imem_wdata_q;
      imem_we_d    = 1'b0;
      err_d        = err_q;
      count_d      = count_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            // A tuple presented alongside start is dropped: ready is still low.
            if (start) begin
               state_d     = ST_LOAD;
               next_addr_d = BASE;
               imem_addr_d = BASE;
               err_d       = 1'b0;
               count_d     = '0;
            end
         end
         ST_LOAD: begin
            if (in_valid) begin
               imem_we_d    = 1'b1;
               imem_addr_d  = next_addr_q;
               imem_wdata_d = packed_word;
               count_d      = count_q + 1'b1;
               err_d        = err_q | packed_illegal;
               // The top word ends the session; the address never wraps.
               if (in_last || next_addr_q == LAST_ADDR) begin
                  state_d = ST_DONE;
               end else begin
                  next_addr_d = next_addr_q + 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         next_addr_q  <= BASE;
         imem_addr_q  <= BASE;
         imem_wdata_q <= '0;
         imem_we_q    <= 1'b0;
         err_q        <= 1'b0;
         count_q      <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the pre-edge values.
         state_q      <= state_d;
         next_addr_q  <= next_addr_d;
         imem_addr_q  <= imem_addr_d;
         imem_wdata_q <= imem_wdata_d;
         imem_we_q    <= imem_we_d;
         err_q        <= err_d;
         count_q      <= count_d;
      end
   end

   assign in_ready    = (state_q == ST_LOAD);
   assign busy        = (state_q == ST_LOAD);
   assign done        = (state_q == ST_DONE);
   assign imem_we     = imem_we_q;
   assign imem_addr   = imem_addr_q;
   assign imem_wdata  = imem_wdata_q;
   assign err_illegal = err_q;
   assign inst_count  = count_q;

endmodule

// File: tb/tb_inst_encoder_loader.sv
// Self-checking bench: directed and random tuples against a field-level
// encoding model; a second instance with ADDR_W=2 exercises the end of memory.
module tb_inst_encoder_loader;

   localparam int AW   = 8;
   localparam int BASE = 0;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start, in_valid, in_last, in_imm_en;
   logic [4:0]  in_op;
   logic [3:0]  in_rd, in_rs1, in_rs2;
   logic [17:0] in_imm;
   logic [26:0] in_offset;

   logic          in_ready, imem_we, busy, done, err_illegal;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_wdata;
   logic [AW:0]   inst_count;

   logic        s_in_ready, s_imem_we, s_busy, s_done, s_err;
   logic [1:0]  s_imem_addr;
   logic [31:0] s_imem_wdata;
   logic [2:0]  s_count;

   always #5 clk = ~clk;

   inst_encoder_loader #(.ADDR_W(AW), .BASE_ADDR(BASE)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
      .in_last(in_last), .in_op(in_op), .in_imm_en(in_imm_en), .in_rd(in_rd), .in_rs1(in_rs1),
      .in_rs2(in_rs2), .in_imm(in_imm), .in_offset(in_offset), .imem_we(imem_we),
      .imem_addr(imem_addr), .imem_wdata(imem_wdata), .busy(busy), .done(done),
      .err_illegal(err_illegal), .inst_count(inst_count)
   );

   inst_encoder_loader #(.ADDR_W(2), .BASE_ADDR(0)) dut_small (
      .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(s_in_ready),
      .in_last(in_last), .in_op(in_op), .in_imm_en(in_imm_en), .in_rd(in_rd), .in_rs1(in_rs1),
      .in_rs2(in_rs2), .in_imm(in_imm), .in_offset(in_offset), .imem_we(s_imem_we),
      .imem_addr(s_imem_addr), .imem_wdata(s_imem_wdata), .busy(s_busy), .done(s_done),
      .err_illegal(s_err), .inst_count(s_count)
   );

   typedef struct {
      int unsigned op, i, rd, rs1, rs2, imm, off;
   } tuple_t;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference session state for the ADDR_W=8 instance.
   bit m_loading = 1'b0;
   bit m_done    = 1'b0;
   bit m_err     = 1'b0;
   int m_count   = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Encoding computed from the instruction-format rules with plain arithmetic.
   function automatic int unsigned ref_word(input tuple_t t);
      int unsigned rd_f, rs1_f, low;
      if (t.op >= 21) return 13 * (1 << 27);
      if (t.op == 13 || t.op == 20) return t.op * (1 << 27);
      if (t.op >= 16 && t.op <= 19) return t.op * (1 << 27) + t.off;
      rd_f  = (t.op == 5) ? 0 : t.rd;
      rs1_f = (t.op == 8 || t.op == 9) ? 0 : t.rs1;
      low   = (t.i != 0) ? t.imm : t.rs2 * (1 << 14);
      return t.op * (1 << 27) + t.i * (1 << 26) + rd_f * (1 << 22) + rs1_f * (1 << 18) + low;
   endfunction

   function automatic tuple_t rand_tuple();
      tuple_t t;
      t.op  = $urandom_range(31, 0);
      t.i   = $urandom_range(1, 0);
      t.rd  = $urandom_range(15, 0);
      t.rs1 = $urandom_range(15, 0);
      t.rs2 = $urandom_range(15, 0);
      t.imm = $urandom_range(32'h3FFFF, 0);
      t.off = $urandom & 32'h07FF_FFFF;
      return t;
   endfunction

   function automatic tuple_t mk(input int unsigned op, i, rd, rs1, rs2, imm, off);
      tuple_t t;
      t.op = op; t.i = i; t.rd = rd; t.rs1 = rs1; t.rs2 = rs2; t.imm = imm; t.off = off;
      return t;
   endfunction

   // One clock of stimulus: drive just after a falling edge, check at the next one.
   task automatic step(input tuple_t t, input bit valid, input bit last, input bit strt);
      bit          acc;
      int unsigned exp_addr;
      in_op     = 5'(t.op);
      in_imm_en = 1'(t.i);
      in_rd     = 4'(t.rd);
      in_rs1    = 4'(t.rs1);
      in_rs2    = 4'(t.rs2);
      in_imm    = 18'(t.imm);
      in_offset = 27'(t.off);
      in_valid  = valid;
      in_last   = last;
      start     = strt;
      #1;
      check("in_ready", 64'(in_ready), 64'(m_loading));
      acc      = valid && m_loading;
      exp_addr = BASE + m_count;
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
      start    = 1'b0;
      check("imem_we", 64'(imem_we), 64'(acc));
      if (acc) begin
         check("imem_addr", 64'(imem_addr), 64'(exp_addr));
         check("imem_wdata", 64'(imem_wdata), 64'(ref_word(t)));
         if (t.op >= 21) m_err = 1'b1;
         m_count++;
         if (last || exp_addr == (1 << AW) - 1) begin
            m_loading = 1'b0;
            m_done    = 1'b1;
         end
      end else if (strt && !m_loading) begin
         m_loading = 1'b1;
         m_done    = 1'b0;
         m_err     = 1'b0;
         m_count   = 0;
      end
      check("busy", 64'(busy), 64'(m_loading));
      check("done", 64'(done), 64'(m_done));
      check("err_illegal", 64'(err_illegal), 64'(m_err));
      check("inst_count", 64'(inst_count), 64'(m_count));
   endtask

   tuple_t t;
   tuple_t idle_t;

   initial begin
      idle_t = mk(0, 0, 0, 0, 0, 0, 0);
      rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_imm_en = 1'b0;
      in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0; in_offset = '0;
      repeat (2) @(negedge clk);

      // Reset state
      check("rst_in_ready", 64'(in_ready), 64'(0));
      check("rst_imem_we", 64'(imem_we), 64'(0));
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_done", 64'(done), 64'(0));
      check("rst_err", 64'(err_illegal), 64'(0));
      check("rst_addr", 64'(imem_addr), 64'(BASE));
      check("rst_wdata", 64'(imem_wdata), 64'(0));
      check("rst_count", 64'(inst_count), 64'(0));
      rst_n = 1'b1;

      // add r1,r2,r3 then add r1,r2,#5 as the last instruction
      step(idle_t, 1'b0, 1'b0, 1'b1);
      step(mk(0, 0, 1, 2, 3, 0, 0), 1'b1, 1'b0, 1'b0);
      check("add_reg_word", 64'(imem_wdata), 64'h0048_C000);
      step(mk(0, 1, 1, 2, 0, 5, 0), 1'b1, 1'b1, 1'b0);
      check("add_imm_word", 64'(imem_wdata), 64'h0448_0005);

      // start together with a tuple in DONE: session begins, tuple dropped
      step(mk(1, 0, 2, 3, 4, 0, 0), 1'b1, 1'b0, 1'b1);

      // branches, cmp and mov with unused fields zeroed
      step(mk(16, 0, 5, 6, 7, 9, 27'h10), 1'b1, 1'b0, 1'b0);
      check("beq_word", 64'(imem_wdata), 64'h8000_0010);
      step(mk(19, 1, 5, 6, 7, 9, 27'h7FF_FFFF), 1'b1, 1'b0, 1'b0);
      check("call_word", 64'(imem_wdata), 64'h9FFF_FFFF);
      step(mk(5, 0, 7, 2, 3, 0, 0), 1'b1, 1'b0, 1'b0);
      check("cmp_word", 64'(imem_wdata), 64'h2808_C000);
      step(mk(9, 1, 4, 9, 0, 18'h3FFFF, 0), 1'b1, 1'b0, 1'b0);
      check("mov_word", 64'(imem_wdata), 64'h4D03_FFFF);

      // illegal opcode: NOP written, sticky flag, address keeps advancing
      step(mk(21, 1, 3, 3, 3, 3, 3), 1'b1, 1'b0, 1'b0);
      check("illegal_word", 64'(imem_wdata), 64'h6800_0000);
      step(mk(2, 0, 1, 1, 1, 0, 0), 1'b1, 1'b0, 1'b1);
      step(mk(13, 0, 1, 1, 1, 0, 0), 1'b1, 1'b1, 1'b0);
      step(idle_t, 1'b0, 1'b0, 1'b1);

      // Random sessions with gaps and ignored mid-session starts
      for (int s = 0; s < 3; s++) begin
         for (int k = 0; k < 12; k++) begin
            bit v, l, st;
            l  = (k == 11);
            v  = l || ($urandom_range(4, 0) != 0);
            st = ($urandom_range(7, 0) == 0);
            step(rand_tuple(), v, l, st);
         end
         step(idle_t, 1'b0, 1'b0, 1'b1);
      end

      // ADDR_W=2 instance: five back-to-back tuples, only four written
      for (int k = 0; k < 5; k++) begin
         check("small_ready", 64'(s_in_ready), 64'(k < 4));
         step(rand_tuple(), 1'b1, 1'b0, 1'b0);
         check("small_we", 64'(s_imem_we), 64'(k < 4));
         if (k < 4) check("small_addr", 64'(s_imem_addr), 64'(k));
         check("small_done", 64'(s_done), 64'(k >= 3));
         check("small_count", 64'(s_count), 64'((k < 4) ? k + 1 : 4));
      end

      // Reset while a write strobe is high
      step(rand_tuple(), 1'b1, 1'b0, 1'b0);
      #1 rst_n = 1'b0;
      #1;
      check("midrst_we", 64'(imem_we), 64'(0));
      check("midrst_addr", 64'(imem_addr), 64'(BASE));
      check("midrst_wdata", 64'(imem_wdata), 64'(0));
      check("midrst_busy", 64'(busy), 64'(0));
      check("midrst_count", 64'(inst_count), 64'(0));
      check("midrst_small_we", 64'(s_imem_we), 64'(0));
      m_loading = 1'b0; m_done = 1'b0; m_err = 1'b0; m_count = 0;
      @(negedge clk);
      rst_n = 1'b1;
      step(idle_t, 1'b0, 1'b0, 1'b1);
      step(mk(14, 1, 2, 3, 0, 18'h1234, 0), 1'b1, 1'b1, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
